// File: rtl/ecc_mem_scrubber.sv
// Background scrubber for 39/32 SECDED memory: read, check, repair and count errors.
// Optional sticky uncorrectable-error address log when ECC_SCRUB_UCE_LOG_EN is defined.
module ecc_mem_scrubber #(
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int INTERVAL = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [38:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [38:0]       mem_rdata,
    output logic              err_valid,
    output logic [1:0]        err_type,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       corr_cnt,
    output logic [15:0]       uncorr_cnt,
    output logic              pass_done,
    output logic              busy
`ifdef ECC_SCRUB_UCE_LOG_EN
    ,
    input  logic              uce_log_clr,
    output logic              uce_log_valid,
    output logic [ADDR_W-1:0] uce_log_addr
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_WR_REQ  = 3'd5;
    localparam logic [2:0] S_NEXT    = 3'd6;

    // Check bits are the XOR of the Hamming positions of all set data bits;
    // data occupies positions 3..38 that are not powers of two, in order.
    function automatic logic [5:0] calc_checks(input logic [31:0] d);
        logic [5:0] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (d[j[4:0]]) c = c ^ 6'(pos);
                j = j + 1;
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] fix_data(input logic [31:0] d, input logic [5:0] s);
        logic [31:0] r;
        int j;
        r = d;
        j = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (6'(pos) == s) r[j[4:0]] = ~r[j[4:0]];
                j = j + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [5:0] c;
        c = calc_checks(d);
        return {^{c, d}, c, d};
    endfunction

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wait_cnt;
    logic [38:0]       rdata_q;
    logic [38:0]       wdata_q;

    logic [5:0]        syn;
    logic              par;
    logic              is_corr;
    logic              is_uncorr;
    logic [31:0]       fixed_data;

    always_comb begin
        syn        = calc_checks(rdata_q[31:0]) ^ rdata_q[37:32];
        par        = ^rdata_q;
        is_corr    = par && (syn <= 6'd38);
        is_uncorr  = ((syn != 6'd0) || par) && !is_corr;
        fixed_data = fix_data(rdata_q[31:0], syn);
    end

    // req/gnt: req, we, addr and wdata hold steady until a cycle in which gnt=1
    // is sampled; read data arrives on a later cycle flagged by rvalid.
    assign mem_req   = (state == S_RD_REQ) || (state == S_WR_REQ);
    assign mem_we    = (state == S_WR_REQ);
    assign mem_addr  = addr;
    assign mem_wdata = wdata_q;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr       <= '0;
            wait_cnt   <= '0;
            rdata_q    <= '0;
            wdata_q    <= '0;
            err_valid  <= 1'b0;
            err_type   <= 2'b00;
            err_addr   <= '0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            pass_done  <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            pass_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 16'(INTERVAL - 1)) begin
                        state <= S_RD_REQ;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_RD_REQ: begin
                    if (mem_gnt) state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (is_corr) begin
                        err_valid <= 1'b1;
                        err_type  <= 2'b01;
                        err_addr  <= addr;
                        if (corr_cnt != 16'hFFFF) corr_cnt <= corr_cnt + 16'd1;
                        wdata_q   <= encode(fixed_data);
                        state     <= S_WR_REQ;
                    end else if (is_uncorr) begin
                        err_valid <= 1'b1;
                        err_type  <= 2'b10;
                        err_addr  <= addr;
                        if (uncorr_cnt != 16'hFFFF) uncorr_cnt <= uncorr_cnt + 16'd1;
                        state     <= S_NEXT;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_WR_REQ: begin
                    if (mem_gnt) state <= S_NEXT;
                end
                S_NEXT: begin
                    if (addr == ADDR_W'(DEPTH - 1)) begin
                        addr      <= '0;
                        pass_done <= 1'b1;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                    wait_cnt <= '0;
                    state    <= en ? S_WAIT : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ECC_SCRUB_UCE_LOG_EN
    logic uce_event;
    assign uce_event = (state == S_CHECK) && is_uncorr;

    // A new error arriving with a clear re-arms the log rather than emptying it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uce_log_valid <= 1'b0;
            uce_log_addr  <= '0;
        end else if (uce_event && (!uce_log_valid || uce_log_clr)) begin
            uce_log_valid <= 1'b1;
            uce_log_addr  <= addr;
        end else if (uce_log_clr) begin
            uce_log_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ecc_mem_scrubber.sv
// Self-checking bench for ecc_mem_scrubber: memory responder, brute-force SECDED model,
// per-cycle compare process and directed scenarios.
`timescale 1ns/1ps
module tb_ecc_mem_scrubber;

    localparam int ADDR_W   = 3;
    localparam int DEPTH    = 4;
    localparam int INTERVAL = 2;
    localparam int IW       = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [38:0]       mem_wdata;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [38:0]       mem_rdata = '0;
    logic              err_valid;
    logic [1:0]        err_type;
    logic [ADDR_W-1:0] err_addr;
    logic [15:0]       corr_cnt;
    logic [15:0]       uncorr_cnt;
    logic              pass_done;
    logic              busy;

    ecc_mem_scrubber #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .INTERVAL(INTERVAL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err_valid(err_valid), .err_type(err_type), .err_addr(err_addr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .pass_done(pass_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [38:0] mem [DEPTH];
    logic [38:0] orig [DEPTH];

    logic [ADDR_W-1:0]  m_addr = '0;
    logic [ADDR_W-1:0]  last_rd = '0;
    logic [15:0]        m_corr = '0;
    logic [15:0]        m_uncorr = '0;
    logic [ADDR_W+1:0]  exp_err_q[$];
    logic [ADDR_W+38:0] exp_wr_q[$];
    logic [ADDR_W+1:0]  err_log[$];
    logic [ADDR_W-1:0]  wr_log[$];
    int n_reads = 0, n_writes = 0, n_errs = 0, n_pass = 0, n_stall = 0;

    bit                rd_pend = 0;
    logic [IW-1:0]     rd_pend_idx = '0;
    int                gnt_block = 0;
    bit                wr_block = 0;
    bit                prev_req = 0, prev_gnt = 0, prev_we = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [38:0]       prev_wdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Textbook placement: data into non-power-of-two positions, each check bit
    // is the parity of all positions whose index has that bit set.
    function automatic logic [38:0] tb_encode(input logic [31:0] d);
        logic [38:0] h;
        logic [5:0]  p;
        logic [38:0] cw;
        int j;
        h = '0;
        p = '0;
        j = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ($countones(pos) != 1) begin
                h[pos[5:0]] = d[j[4:0]];
                j++;
            end
        end
        for (int k = 0; k < 6; k++)
            for (int pos = 1; pos <= 38; pos++)
                if (pos[k]) p[k] = p[k] ^ h[pos[5:0]];
        cw = {1'b0, p, d};
        cw[38] = ^cw[37:0];
        return cw;
    endfunction

    // 0 = clean, 1 = one bit away from a valid codeword, 2 = uncorrectable.
    function automatic int tb_classify(input logic [38:0] cw, output logic [38:0] fixed);
        logic [38:0] t;
        fixed = cw;
        if (tb_encode(cw[31:0]) == cw) return 0;
        for (int i = 0; i < 39; i++) begin
            t = cw ^ (39'd1 << i);
            if (tb_encode(t[31:0]) == t) begin
                fixed = t;
                return 1;
            end
        end
        return 2;
    endfunction

    task automatic predict(input logic [38:0] cw, input logic [ADDR_W-1:0] a);
        logic [38:0] fx;
        int cls;
        cls = tb_classify(cw, fx);
        if (cls == 1) begin
            exp_err_q.push_back({2'b01, a});
            exp_wr_q.push_back({a, fx});
        end else if (cls == 2) begin
            exp_err_q.push_back({2'b10, a});
        end
        m_addr = (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endtask

    // Memory responder and per-cycle compare, all at the falling edge.
    always @(negedge clk) begin
        logic [ADDR_W+1:0] e;
        logic [IW-1:0]     idx;
        if (!rst_n) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            rd_pend = 0;
            prev_req = 0;
            prev_gnt = 0;
        end else begin
            mem_rvalid = 1'b0;
            if (rd_pend) begin
                mem_rvalid = 1'b1;
                mem_rdata = mem[rd_pend_idx];
                rd_pend = 0;
            end
            if (prev_req && !prev_gnt)
                check("req_stable", {mem_req, mem_we, mem_addr, mem_wdata},
                      {1'b1, prev_we, prev_addr, prev_wdata});
            mem_gnt = mem_req && (gnt_block == 0) && !(mem_we && wr_block);
            if (mem_req && !mem_gnt) begin
                n_stall++;
                if (gnt_block > 0) gnt_block--;
            end
            idx = mem_addr[IW-1:0];
            if (mem_gnt && !mem_we) begin
                check("rd_addr", mem_addr, m_addr);
                n_reads++;
                last_rd = mem_addr;
                predict(mem[idx], mem_addr);
                rd_pend = 1;
                rd_pend_idx = idx;
            end
            if (mem_gnt && mem_we) begin
                n_writes++;
                wr_log.push_back(mem_addr);
                if (exp_wr_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got write addr %0d data %0h, none required", mem_addr, mem_wdata);
                end else begin
                    check("wr", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
                end
                mem[idx] = mem_wdata;
            end
            if (err_valid) begin
                n_errs++;
                err_log.push_back({err_type, err_addr});
                if (exp_err_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL err_unexpected: got type %0b addr %0d, none required", err_type, err_addr);
                end else begin
                    e = exp_err_q.pop_front();
                    check("err", {err_type, err_addr}, e);
                    if (e[ADDR_W+1:ADDR_W] == 2'b01) begin
                        if (m_corr != 16'hFFFF) m_corr++;
                    end else begin
                        if (m_uncorr != 16'hFFFF) m_uncorr++;
                    end
                end
            end
            check("corr_cnt", corr_cnt, m_corr);
            check("uncorr_cnt", uncorr_cnt, m_uncorr);
            if (pass_done) begin
                n_pass++;
                check("pass_last_addr", last_rd, DEPTH - 1);
            end
            prev_req = mem_req;
            prev_gnt = mem_gnt;
            prev_we = mem_we;
            prev_addr = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cond_met(input int what, input int target);
        case (what)
            0: return n_reads >= target;
            1: return n_writes >= target;
            2: return n_pass >= target;
            3: return !busy;
            4: return mem_req;
            default: return mem_req && mem_we;
        endcase
    endfunction

    task automatic wait_for(input string name, input int what, input int target, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (cond_met(what, target)) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL timeout_%s: condition not reached within %0d cycles", name, budget);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_err_valid"}, err_valid, 0);
        check({tag, "_err_type"}, err_type, 0);
        check({tag, "_err_addr"}, err_addr, 0);
        check({tag, "_corr_cnt"}, corr_cnt, 0);
        check({tag, "_uncorr_cnt"}, uncorr_cnt, 0);
        check({tag, "_pass_done"}, pass_done, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [38:0] fx;
        int cls, s0, r0, w0;

        for (int i = 0; i < DEPTH; i++) begin
            orig[i] = tb_encode(32'hC0DE_0000 + 32'(i) * 32'h0101_1111);
            mem[i] = orig[i];
        end

        // Hand-computed codewords pin the model encoder and classifier.
        check("enc_zero", tb_encode(32'h0), 39'h0);
        check("enc_bit0", tb_encode(32'h1), 39'h43_0000_0001);
        check("enc_bit5", tb_encode(32'h20), 39'h4A_0000_0020);
        check("enc_bit31", tb_encode(32'h8000_0000), 39'h26_8000_0000);
        cls = tb_classify(39'h4A_0000_0020 ^ 39'h3, fx);
        check("cls_double", cls, 2);
        cls = tb_classify(39'h4A_0000_0000, fx);
        check("cls_single", cls, 1);
        check("cls_single_fix", fx, 39'h4A_0000_0020);

        // Reset
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Clean pass
        en = 1'b1;
        wait_for("pass1", 2, 1, 200);
        en = 1'b0;
        wait_for("idle1", 3, 0, 50);
        check("s1_reads", n_reads, 4);
        check("s1_writes", n_writes, 0);
        check("s1_errs", n_errs, 0);
        check("s1_passes", n_pass, 1);

        // pG error at 0, double error at 1, data bit 5 at 2
        mem[0] = orig[0] ^ (39'd1 << 38);
        mem[1] = orig[1] ^ 39'h3;
        mem[2] = orig[2] ^ (39'd1 << 5);
        en = 1'b1;
        wait_for("pass2", 2, 2, 200);
        en = 1'b0;
        wait_for("idle2", 3, 0, 50);
        check("s2_reads", n_reads, 8);
        check("s2_writes", n_writes, 2);
        check("s2_corr", corr_cnt, 2);
        check("s2_uncorr", uncorr_cnt, 1);
        check("s2_errlog_n", err_log.size(), 3);
        if (err_log.size() == 3) begin
            check("s2_err0", err_log[0], {2'b01, 3'd0});
            check("s2_err1", err_log[1], {2'b10, 3'd1});
            check("s2_err2", err_log[2], {2'b01, 3'd2});
        end
        check("s2_wrlog_n", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check("s2_wr0", wr_log[0], 0);
            check("s2_wr1", wr_log[1], 2);
        end
        check("s2_mem0", mem[0], orig[0]);
        check("s2_mem1", mem[1], orig[1] ^ 39'h3);
        check("s2_mem2", mem[2], orig[2]);

        // Grant withheld 5 cycles; en dropped while the read is pending
        s0 = n_stall;
        gnt_block = 5;
        en = 1'b1;
        wait_for("s3_req", 4, 0, 50);
        en = 1'b0;
        wait_for("idle3", 3, 0, 50);
        check("s3_reads", n_reads, 9);
        check("s3_rd_addr", last_rd, 0);
        check("s3_stalls", n_stall - s0, 5);

        // Saturated corrected count plus one more single error (check bit p8 at addr 1)
        m_corr = 16'hFFFF;
        force dut.corr_cnt = 16'hFFFF;
        tick();
        release dut.corr_cnt;
        mem[1] = orig[1] ^ (39'd1 << 35);
        w0 = n_writes;
        en = 1'b1;
        wait_for("s4_wr", 1, w0 + 1, 50);
        en = 1'b0;
        wait_for("idle4", 3, 0, 50);
        check("s4_corr_sat", corr_cnt, 16'hFFFF);
        check("s4_rd_addr", last_rd, 1);
        check("s4_mem1", mem[1], orig[1]);
        if (wr_log.size() > 0) check("s4_wr_addr", wr_log[wr_log.size() - 1], 1);

        // Reset while a writeback is waiting for its grant
        mem[2] = orig[2] ^ (39'd1 << 10);
        wr_block = 1;
        en = 1'b1;
        wait_for("s5_wrreq", 5, 0, 50);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wr");
        m_corr = '0;
        m_uncorr = '0;
        m_addr = '0;
        exp_err_q.delete();
        exp_wr_q.delete();
        wr_block = 0;
        en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("s5_busy_after_rst", busy, 0);

        // Scan restarts at address 0 after reset
        r0 = n_reads;
        en = 1'b1;
        wait_for("s6_rd", 0, r0 + 1, 50);
        en = 1'b0;
        wait_for("idle6", 3, 0, 50);
        check("s6_rd_addr", last_rd, 0);
        check("s6_corr", corr_cnt, 0);
        check("end_err_q", exp_err_q.size(), 0);
        check("end_wr_q", exp_wr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_mem_scrubber.md
Name: ecc_mem_scrubber

Overview:
- Background scrubber for a memory array protected by the team's 32/39 SECDED code.
- Codeword layout is {pG, p32, p16, p8, p4, p2, p1, data[31:0]}:
  - bits 31:0 are data;
  - bits 37:32 are Hamming checks p1..p32;
  - bit 38 is the overall parity of bits 37:0.
- Walks every address and reads each codeword through a req/gnt memory port. It decodes the codeword, writes back a re-encoded corrected codeword on any correctable error, and counts and reports errors.
- Sits beside the memory arbiter as a low-priority requester. It is the reader/repairer counterpart to the write-side encoder.

Parameters:
- ADDR_W, 10, address width.
- DEPTH, 1024, number of words scrubbed; 2 <= DEPTH <= 2**ADDR_W.
- INTERVAL, 256, idle cycles between word scrubs; 1 <= INTERVAL <= 65535.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scrub enable.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  39  write codeword.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  39  read codeword.
- err_valid  out  1  one-cycle pulse on any detected error.
- err_type  out  2  01 = corrected single, 10 = uncorrectable; valid with err_valid.
- err_addr  out  ADDR_W  address of the error; valid with err_valid.
- corr_cnt  out  16  corrected-error count, saturating.
- uncorr_cnt  out  16  uncorrectable count, saturating.
- pass_done  out  1  one-cycle pulse when address DEPTH-1 completes.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - all outputs 0; scrub address 0; interval counter 0; FSM in IDLE.
  - Reset mid-transaction abandons the transaction immediately. No retry is made after reset.
- FSM states and transitions:
  - IDLE: if en, go to WAIT and clear the interval counter.
  - WAIT: count clk cycles. After INTERVAL cycles go to RD_REQ. If en drops during WAIT, return to IDLE.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=scrub address. Hold until mem_gnt=1 is sampled, then go to RD_WAIT. req/addr/we are stable while waiting.
  - RD_WAIT: wait for mem_rvalid, which is at least 1 cycle after gnt. Capture mem_rdata, go to CHECK.
  - CHECK (1 cycle):
    - compute syndrome s[5:0] = recomputed p1..p32 XOR stored bits 37:32;
    - compute overall parity P = XOR of bits 38:0;
    - then classify:
      - s=0, P=0: clean; go to NEXT.
      - s=0, P=1: pG bit error; correctable.
      - s!=0, P=1, s<=38: single error at Hamming position s (data or check bit); correctable. Flip the data bit at s if s is a data position.
      - s!=0, P=1, s>38: uncorrectable.
      - s!=0, P=0: double error; uncorrectable.
    - Correctable: pulse err_valid with type 01, increment corr_cnt, go to WR_REQ.
    - Uncorrectable: pulse err_valid with type 10, increment uncorr_cnt, no writeback, go to NEXT.
    - err_valid is registered and asserted in the cycle after CHECK.
  - WR_REQ: mem_req=1, mem_we=1, mem_wdata = fresh encode of the corrected data (all checks and pG recomputed). Hold until mem_gnt, then go to NEXT.
  - NEXT:
    - if the address is DEPTH-1, wrap it to 0 and pulse pass_done; otherwise increment it.
    - Then go to WAIT if en, else IDLE.
- en deassert mid-scrub: RD_REQ through WR_REQ always complete. An issued request is never withdrawn. The address is retained across disable/enable.
- Counters saturate at 16'hFFFF; they do not wrap. They clear only on reset.
- Memory timing: no combinational path from mem_rdata to mem_req/mem_wdata.
- Minimum scrub latency per word: INTERVAL + 1 (req) + 1 (rvalid) + 1 (CHECK) + 1 (NEXT) cycles, plus 1 cycle if a writeback occurs.

Optional Feature:
- Macro: ECC_SCRUB_UCE_LOG_EN.
- Defined:
  - adds ports uce_log_clr in 1, uce_log_valid out 1, uce_log_addr out ADDR_W;
  - the first uncorrectable error latches its address and sets valid;
  - the log is sticky: later errors are ignored until uce_log_clr=1, which clears valid next cycle;
  - if a clear and a new uncorrectable error occur in the same cycle, the new error wins;
  - reset clears the log.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Clean pass: DEPTH=4, INTERVAL=2, all words correctly encoded, memory grants immediately.
  - Required: 4 reads, 0 writes, no err_valid, one pass_done after address 3, address wraps to 0.
- Data bit 5 flipped at address 2 (Hamming position 10).
  - Required: err_valid with type 01, err_addr=2, corr_cnt=1, a write to address 2 with the original codeword.
- Bits 0 and 1 flipped at address 1.
  - Required: type 10, uncorr_cnt=1, no write, scan continues to address 2.
- Only bit 38 (pG) flipped at address 0.
  - Required: type 01, write restores the correct pG.
- mem_gnt held low for 5 cycles during RD_REQ, with en dropped in that window.
  - Required: mem_req, mem_addr and mem_we stable throughout; the word completes; the FSM goes to IDLE with the address incremented.
- Force corr_cnt to 16'hFFFF, then inject one more single error.
  - Required: the count stays at 16'hFFFF.
- Reset pulsed during WR_REQ.
  - Required: mem_req=0 immediately and every output is 0.
